lsu_load_unit: RTL and testbench
================================

Name: lsu_load_unit

Overview:
Load-side counterpart of the LSU byte/word store register: it reads 32-bit words from a word-addressed data memory and returns byte, halfword or word results to the pipeline.
- Accepts one load request at a time over a valid/ready handshake.
- Issues word reads to a memory with 1-cycle read latency.
- Assembles misaligned data that spans two words, then zero- or sign-extends the result.
- Holds the result on a valid/ready response channel until the consumer takes it.

Parameters:
ADDR_W, 32, byte-address width (ADDR_W >= 4).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  load request valid
req_ready  output  1  unit can accept a request (high only in IDLE)
req_addr  input  ADDR_W  byte address
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
req_unsigned  input  1  1 = zero-extend, 0 = sign-extend (ignored for word)
mem_rd_en  output  1  memory read strobe
mem_addr  output  ADDR_W-2  word address
mem_rdata  input  32  read data, valid the cycle after mem_rd_en
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_data  output  32  extended load result
rsp_err  output  1  request error (reserved size, or misaligned when split disabled)

Behaviour:
Reset
- Synchronous, active-high.
- Next edge: state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, captured words cleared.
- mem_rd_en and mem_addr are combinational from state: 0 in IDLE with no request.
- A reset mid-operation drops the in-flight load; no response is produced.

Decode at accept
- Accept when req_valid && req_ready.
- Register addr[1:0]=off, size, unsigned, and word index W=addr[ADDR_W-1:2].
- Split access: (size=01 && off=3) or (size=10 && off!=0).
- Reserved size (11): no memory access; go to RESP with rsp_err=1, rsp_data=0; rsp_valid at T+1.

State machine (IDLE, RD0, RD1, RESP)
- IDLE: req_ready=1. On accept (cycle T): mem_rd_en=1, mem_addr=W; go to RD0.
- RD0: capture mem_rdata as w0.
  - If split: mem_rd_en=1, mem_addr=W+1, wrapping modulo 2^(ADDR_W-2) (all-ones wraps to 0); go to RD1.
  - Else: compute result; go to RESP.
- RD1: capture mem_rdata as w1; compute result; go to RESP.
- RESP: rsp_valid=1 and rsp_data/rsp_err held stable. On rsp_ready, go to IDLE. A new request is accepted no earlier than the cycle after the handshake.

Latency
- Aligned load: rsp_valid first high at T+2.
- Split load: rsp_valid first high at T+3.

Extraction and extension
- Form the 64-bit value {w1,w0}; w1=0 if not split.
- Shift right by 8*off and take the low 8/16/32 bits.
- Byte/half: sign-extend from bit 7/15 unless req_unsigned.
- Word: used as-is.
- All registered outputs change only on state transitions.

Optional Feature:
LSU_LOAD_SPLIT_EN
- Defined: split accesses handled as above (two reads, assembled result, rsp_err=0).
- Undefined:
  - Split accesses issue no memory read (mem_rd_en stays 0).
  - Go directly IDLE->RESP with rsp_err=1, rsp_data=0; rsp_valid at T+1.
  - RD1 state and w1 register are removed.

Test Plan:
(memory: word0=0x80FF7F01, word1=0xDEADBEEF)
- LB 0x2 signed -> 0xFFFFFFFF; LBU 0x1 -> 0x0000007F; LB 0x3 -> 0xFFFFFF80. Each has one mem_rd_en with mem_addr=0 and rsp_valid at T+2.
- LH 0x0 signed -> 0x00007F01; LH 0x2 signed -> 0xFFFF80FF; LHU 0x2 -> 0x000080FF; LW 0x0 -> 0x80FF7F01.
- LW 0x1:
  - With LSU_LOAD_SPLIT_EN: reads at mem_addr 0 then 1, rsp_data=0xEF80FF7F, rsp_err=0, rsp_valid at T+3.
  - Without: no mem_rd_en, rsp_err=1, rsp_data=0 at T+1.
- Backpressure: LH 0x3 (with split) while rsp_ready is held low 3 cycles -> rsp_data=0xEF80 sign-extended to 0xFFFFEF80, stable; req_ready=0 throughout; returns to IDLE the cycle after rsp_ready=1.
- req_size=11 at addr 0x0 -> no mem_rd_en, rsp_err=1, rsp_data=0, rsp_valid at T+1. Wrap case: LW at addr 0xFFFFFFFE (split) reads mem_addr 0x3FFFFFFF then 0x00000000.
- Assert rst while in RD0 of a split load -> next cycle state=IDLE, rsp_valid=0, mem_rd_en=0, req_ready=1; no response ever emitted for that load.

Source files
------------

// File: rtl/lsu_load_unit.sv
// Load unit: reads 32-bit words from a word-addressed memory with 1-cycle read latency
// and returns zero/sign-extended byte, halfword or word results over a valid/ready channel.
// Build option: define LSU_LOAD_SPLIT_EN to service loads that straddle two words with a
// second read; without it such loads complete immediately with rsp_err set.
`timescale 1ns/1ps
module lsu_load_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_rd_en,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeRsvd = 2'b11;

`ifdef LSU_LOAD_SPLIT_EN
  localparam logic [ADDR_W-3:0] WordOne = {{(ADDR_W-3){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRd0, StRd1, StResp} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRd0, StResp} state_e;
`endif

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
`ifdef LSU_LOAD_SPLIT_EN
  // Word index and first word are only needed to issue and assemble the second read.
  logic [ADDR_W-3:0] widx_q, widx_d;
  logic              split_q, split_d;
  logic [31:0]       w0_q, w0_d;
`endif

  logic [ADDR_W-3:0] req_word;
  logic              req_split;
  logic              req_bad;

  // Shift the two-word window down to the addressed byte, then truncate and extend.
  function automatic logic [31:0] extract(input logic [63:0] dword, input logic [1:0] off,
                                          input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = 32'(dword >> {off, 3'b000});
    case (size)
      SizeByte: extract = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SizeHalf: extract = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default:  extract = sh;
    endcase
  endfunction

  // Request decode: word index, straddle detection and requests answered without a read.
  always_comb begin
    req_word  = req_addr[ADDR_W-1:2];
    req_split = ((req_size == SizeHalf) && (req_addr[1:0] == 2'd3)) ||
                ((req_size == SizeWord) && (req_addr[1:0] != 2'd0));
`ifdef LSU_LOAD_SPLIT_EN
    req_bad   = (req_size == SizeRsvd);
`else
    req_bad   = (req_size == SizeRsvd) || req_split;
`endif
  end

  // Next-state, memory strobe and result computation.
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    data_d    = data_q;
    err_d     = err_q;
`ifdef LSU_LOAD_SPLIT_EN
    widx_d    = widx_q;
    split_d   = split_q;
    w0_d      = w0_q;
`endif
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          off_d  = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
`ifdef LSU_LOAD_SPLIT_EN
          widx_d  = req_word;
          split_d = req_split;
`endif
          if (req_bad) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            mem_rd_en = 1'b1;
            mem_addr  = req_word;
            err_d     = 1'b0;
            state_d   = StRd0;
          end
        end
      end
      StRd0: begin
`ifdef LSU_LOAD_SPLIT_EN
        w0_d = mem_rdata;
        if (split_q) begin
          // Word index wraps naturally at the top of the address space.
          mem_rd_en = 1'b1;
          mem_addr  = widx_q + WordOne;
          state_d   = StRd1;
        end else begin
          data_d  = extract({32'b0, mem_rdata}, off_q, size_q, uns_q);
          state_d = StResp;
        end
`else
        data_d  = extract({32'b0, mem_rdata}, off_q, size_q, uns_q);
        state_d = StResp;
`endif
      end
`ifdef LSU_LOAD_SPLIT_EN
      StRd1: begin
        // Second word arrives now and is folded straight into the result.
        data_d  = extract({mem_rdata, w0_q}, off_q, size_q, uns_q);
        state_d = StResp;
      end
`endif
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and captured request/result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef LSU_LOAD_SPLIT_EN
      widx_q  <= '0;
      split_q <= 1'b0;
      w0_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef LSU_LOAD_SPLIT_EN
      widx_q  <= widx_d;
      split_q <= split_d;
      w0_q    <= w0_d;
`endif
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_load_unit.sv
// Directed bench for lsu_load_unit; expectations follow the build's LSU_LOAD_SPLIT_EN setting.
`timescale 1ns/1ps
module tb_lsu_load_unit;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              mem_rd_en;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  int checks = 0;
  int passes = 0;
  int rd_cnt = 0;
  logic [29:0] rd_log [64];

  lsu_load_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    case (a)
      30'h0:        mem_word = 32'h80FF7F01;
      30'h1:        mem_word = 32'hDEADBEEF;
      30'h3FFFFFFF: mem_word = 32'h12345678;
      default:      mem_word = 32'h0;
    endcase
  endfunction

  // Memory model with 1-cycle read latency; logs every read address.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata          <= mem_word(mem_addr);
      rd_log[rd_cnt[5:0]] <= mem_addr;
      rd_cnt             <= rd_cnt + 1;
    end
  end

  // Drives one request from IDLE, measures latency, collects the response and read log.
  task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          output logic rdy0, output int lat, output logic [31:0] data,
                          output logic err, output int nreads,
                          output logic [29:0] a0, output logic [29:0] a1);
    int base;
    base         = rd_cnt;
    rdy0         = req_ready;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_valid    = 1'b1;
    rsp_ready    = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat       = 0;
    for (int k = 1; k <= 6; k++) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    data      = rsp_data;
    err       = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    nreads    = rd_cnt - base;
    a0        = rd_log[base % 64];
    a1        = rd_log[(base + 1) % 64];
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_size = 2'b00; req_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passes++;
    checks++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 00000000", rsp_data); else passes++;
    checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", rsp_err); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passes++;
    checks++; if (mem_rd_en !== 1'b0) $display("FAIL reset_mem_rd_en: got %b want 0", mem_rd_en); else passes++;
    checks++; if (mem_addr !== 30'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_byte();
    logic [31:0] addrs [3] = '{32'h2, 32'h1, 32'h3};
    logic        unss  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [3] = '{32'hFFFFFFFF, 32'h0000007F, 32'hFFFFFF80};
    logic rdy0, err; int lat, nr; logic [31:0] data; logic [29:0] a0, a1;
    for (int i = 0; i < 3; i++) begin
      run_load(addrs[i], 2'b00, unss[i], rdy0, lat, data, err, nr, a0, a1);
      checks++; if (rdy0 !== 1'b1) $display("FAIL lb_ready[%0d]: got %b want 1", i, rdy0); else passes++;
      checks++; if (data !== exps[i]) $display("FAIL lb_data[%0d]: got %h want %h", i, data, exps[i]); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL lb_err[%0d]: got %b want 0", i, err); else passes++;
      checks++; if (lat != 2) $display("FAIL lb_latency[%0d]: got %0d want 2", i, lat); else passes++;
      checks++; if (nr != 1) $display("FAIL lb_reads[%0d]: got %0d want 1", i, nr); else passes++;
      checks++; if (a0 !== 30'h0) $display("FAIL lb_addr[%0d]: got %h want 0", i, a0); else passes++;
    end
  endtask

  task automatic test_half_word();
    logic [31:0] addrs [4] = '{32'h0, 32'h2, 32'h2, 32'h0};
    logic [1:0]  sizes [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    logic        unss  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [4] = '{32'h00007F01, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
    logic rdy0, err; int lat, nr; logic [31:0] data; logic [29:0] a0, a1;
    for (int i = 0; i < 4; i++) begin
      run_load(addrs[i], sizes[i], unss[i], rdy0, lat, data, err, nr, a0, a1);
      checks++; if (data !== exps[i]) $display("FAIL lh_lw_data[%0d]: got %h want %h", i, data, exps[i]); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL lh_lw_err[%0d]: got %b want 0", i, err); else passes++;
      checks++; if (lat != 2) $display("FAIL lh_lw_latency[%0d]: got %0d want 2", i, lat); else passes++;
      checks++; if (nr != 1) $display("FAIL lh_lw_reads[%0d]: got %0d want 1", i, nr); else passes++;
    end
  endtask

  task automatic test_split();
    logic rdy0, err; int lat, nr; logic [31:0] data; logic [29:0] a0, a1;
    run_load(32'h1, 2'b10, 1'b0, rdy0, lat, data, err, nr, a0, a1);
`ifdef LSU_LOAD_SPLIT_EN
    checks++; if (data !== 32'hEF80FF7F) $display("FAIL split_data: got %h want ef80ff7f", data); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL split_err: got %b want 0", err); else passes++;
    checks++; if (lat != 3) $display("FAIL split_latency: got %0d want 3", lat); else passes++;
    checks++; if (nr != 2) $display("FAIL split_reads: got %0d want 2", nr); else passes++;
    checks++; if (a0 !== 30'h0) $display("FAIL split_addr0: got %h want 0", a0); else passes++;
    checks++; if (a1 !== 30'h1) $display("FAIL split_addr1: got %h want 1", a1); else passes++;
`else
    checks++; if (data !== 32'h0) $display("FAIL split_data: got %h want 00000000", data); else passes++;
    checks++; if (err !== 1'b1) $display("FAIL split_err: got %b want 1", err); else passes++;
    checks++; if (lat != 1) $display("FAIL split_latency: got %0d want 1", lat); else passes++;
    checks++; if (nr != 0) $display("FAIL split_reads: got %0d want 0", nr); else passes++;
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
`ifdef LSU_LOAD_SPLIT_EN
    exp_data = 32'hFFFFEF80; exp_err = 1'b0; exp_lat = 3;
`else
    exp_data = 32'h0; exp_err = 1'b1; exp_lat = 1;
`endif
    req_addr = 32'h3; req_size = 2'b01; req_unsigned = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      checks++; if (req_ready !== 1'b0) $display("FAIL bp_busy_ready[%0d]: got %b want 0", k, req_ready); else passes++;
      @(posedge clk); #1;
    end
    checks++; if (lat != exp_lat) $display("FAIL bp_latency: got %0d want %0d", lat, exp_lat); else passes++;
    for (int k = 0; k < 3; k++) begin
      checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", k, rsp_valid); else passes++;
      checks++; if (rsp_data !== exp_data) $display("FAIL bp_data[%0d]: got %h want %h", k, rsp_data, exp_data); else passes++;
      checks++; if (rsp_err !== exp_err) $display("FAIL bp_err[%0d]: got %b want %b", k, rsp_err, exp_err); else passes++;
      checks++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %b want 0", k, req_ready); else passes++;
      @(posedge clk); #1;
    end
    checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid_before_ack: got %b want 1", rsp_valid); else passes++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) $display("FAIL bp_idle_ready: got %b want 1", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_idle_valid: got %b want 0", rsp_valid); else passes++;
  endtask

  task automatic test_wrap();
    logic rdy0, err; int lat, nr; logic [31:0] data; logic [29:0] a0, a1;
    run_load(32'hFFFFFFFE, 2'b10, 1'b0, rdy0, lat, data, err, nr, a0, a1);
`ifdef LSU_LOAD_SPLIT_EN
    checks++; if (nr != 2) $display("FAIL wrap_reads: got %0d want 2", nr); else passes++;
    checks++; if (a0 !== 30'h3FFFFFFF) $display("FAIL wrap_addr0: got %h want 3fffffff", a0); else passes++;
    checks++; if (a1 !== 30'h0) $display("FAIL wrap_addr1: got %h want 0", a1); else passes++;
    checks++; if (data !== 32'h7F011234) $display("FAIL wrap_data: got %h want 7f011234", data); else passes++;
    checks++; if (lat != 3) $display("FAIL wrap_latency: got %0d want 3", lat); else passes++;
`else
    checks++; if (nr != 0) $display("FAIL wrap_reads: got %0d want 0", nr); else passes++;
    checks++; if (err !== 1'b1) $display("FAIL wrap_err: got %b want 1", err); else passes++;
    checks++; if (lat != 1) $display("FAIL wrap_latency: got %0d want 1", lat); else passes++;
`endif
  endtask

  task automatic test_reserved();
    logic rdy0, err; int lat, nr; logic [31:0] data; logic [29:0] a0, a1;
    run_load(32'h0, 2'b11, 1'b0, rdy0, lat, data, err, nr, a0, a1);
    checks++; if (data !== 32'h0) $display("FAIL rsvd_data: got %h want 00000000", data); else passes++;
    checks++; if (err !== 1'b1) $display("FAIL rsvd_err: got %b want 1", err); else passes++;
    checks++; if (lat != 1) $display("FAIL rsvd_latency: got %0d want 1", lat); else passes++;
    checks++; if (nr != 0) $display("FAIL rsvd_reads: got %0d want 0", nr); else passes++;
  endtask

  task automatic test_reset_midload();
    logic seen;
`ifdef LSU_LOAD_SPLIT_EN
    req_addr = 32'h1; req_size = 2'b10;
`else
    req_addr = 32'h2; req_size = 2'b00;
`endif
    req_unsigned = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", rsp_valid); else passes++;
    checks++; if (mem_rd_en !== 1'b0) $display("FAIL midrst_rd_en: got %b want 0", mem_rd_en); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", req_ready); else passes++;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL midrst_no_rsp: got %b want 0", seen); else passes++;
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half_word();
    test_split();
    test_backpressure();
    test_wrap();
    test_reserved();
    test_reset_midload();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
